// File: rtl/counter_event_mon_if.sv
// Event record stream from counter_event_mon to its consumer: valid/ready handshake
// carrying a 2-bit record type and the 8-bit counter value captured with it.
interface counter_event_mon_if;
    logic       evt_valid_out;
    logic       evt_ready_in;
    logic [1:0] evt_type_out;
    logic [7:0] evt_value_out;

    modport master (
        output evt_valid_out,
        output evt_type_out,
        output evt_value_out,
        input  evt_ready_in
    );

    modport slave (
        input  evt_valid_out,
        input  evt_type_out,
        input  evt_value_out,
        output evt_ready_in
    );
endinterface

// File: rtl/counter_event_mon.sv
// Watches an 8-bit counter for overflow and wrap events and queues typed records in a FIFO.
// Define COUNTER_EVT_MON_CMP_EVT_EN to add the cmp_in port and compare-match (CMP) events.
module counter_event_mon #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_ctrl_in,
    input  logic [7:0]           counter_in,
    input  logic                 ovf_in,
`ifdef COUNTER_EVT_MON_CMP_EVT_EN
    input  logic [7:0]           cmp_in,
`endif
    counter_event_mon_if.master  evt_if,
    output logic [15:0]          ovf_cnt_out,
    output logic [7:0]           drop_cnt_out,
    output logic                 fifo_full_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_OVF     = 2'b00;
    localparam logic [1:0] TYPE_CMP     = 2'b01;
    localparam logic [1:0] TYPE_WRAP_UP = 2'b10;
    localparam logic [1:0] TYPE_WRAP_DN = 2'b11;

    // Previous-sample history
    logic [7:0]       cnt_prev_reg;
    logic             ovf_prev_reg;

    // FIFO storage and bookkeeping
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [9:0]       head_reg;

    // Statistics
    logic [15:0]      ovf_cnt_reg;
    logic [15:0]      ovf_cnt_next;
    logic [7:0]       drop_cnt_reg;
    logic [7:0]       drop_cnt_next;
    logic [8:0]       drop_sum;

    // Detection and push arbitration
    logic             det_en;
    logic             ovf_det;
    logic             wrap_up_det;
    logic             wrap_dn_det;
    logic             cmp_det;
    logic             push_valid;
    logic [1:0]       push_type;
    logic [9:0]       push_rec;
    logic [1:0]       lower_cnt;
    logic [1:0]       drop_inc;
    logic             pop;
    logic             push_accept;
    logic             push_discard;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head_load_push;
    logic             head_load_mem;

    // Nothing is detected in a reset cycle, so the history and FIFO come up clean.
    assign det_en      = en_ctrl_in & ~rst_in;
    assign ovf_det     = det_en & ovf_in & ~ovf_prev_reg;
    assign wrap_up_det = det_en & (cnt_prev_reg == 8'hFF) & (counter_in == 8'h00);
    assign wrap_dn_det = det_en & (cnt_prev_reg == 8'h00) & (counter_in == 8'hFF);

`ifdef COUNTER_EVT_MON_CMP_EVT_EN
    assign cmp_det = det_en & (counter_in == cmp_in) & (counter_in != cnt_prev_reg);
`else
    assign cmp_det = 1'b0;
`endif

    always_comb begin
        push_valid = 1'b1;
        push_type  = TYPE_OVF;
        lower_cnt  = 2'd0;
        if (wrap_up_det) begin
            push_type = TYPE_WRAP_UP;
            lower_cnt = {1'b0, ovf_det} + {1'b0, cmp_det};
        end else if (wrap_dn_det) begin
            push_type = TYPE_WRAP_DN;
            lower_cnt = {1'b0, ovf_det} + {1'b0, cmp_det};
        end else if (ovf_det) begin
            push_type = TYPE_OVF;
            lower_cnt = {1'b0, cmp_det};
        end else if (cmp_det) begin
            push_type = TYPE_CMP;
        end else begin
            push_valid = 1'b0;
        end
    end

    assign push_rec = {push_type, counter_in};

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop          = ~fifo_empty & evt_if.evt_ready_in;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_accept  = push_valid & (~fifo_full | pop);
    assign push_discard = push_valid & ~push_accept;
    assign count_next   = count_reg + CNT_W'(push_accept) - CNT_W'(pop);
    assign rd_ptr_next  = rd_ptr_reg + PTR_W'(1);

    // Outranked events and a rejected push can coincide: up to three drops per cycle.
    assign drop_inc      = lower_cnt + {1'b0, push_discard};
    assign drop_sum      = {1'b0, drop_cnt_reg} + {7'd0, drop_inc};
    assign drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    assign ovf_cnt_next  = (ovf_det && (ovf_cnt_reg != 16'hFFFF)) ? ovf_cnt_reg + 16'd1
                                                                    : ovf_cnt_reg;

    // The head register mirrors mem[rd_ptr]; it is refilled from the array or the push path.
    always_comb begin
        head_load_push = 1'b0;
        head_load_mem  = 1'b0;
        if (fifo_empty) begin
            head_load_push = push_accept;
        end else if (pop) begin
            if (count_reg > CNT_W'(1)) begin
                head_load_mem = 1'b1;
            end else begin
                head_load_push = push_accept;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= push_rec;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_prev_reg <= 8'h00;
            ovf_prev_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            ovf_cnt_reg  <= 16'h0000;
            drop_cnt_reg <= 8'h00;
        end else begin
            cnt_prev_reg <= counter_in;
            ovf_prev_reg <= ovf_in;
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            count_reg <= count_next;
            if (head_load_mem) begin
                head_reg <= mem[rd_ptr_next];
            end else if (head_load_push) begin
                head_reg <= push_rec;
            end
            ovf_cnt_reg  <= ovf_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign evt_if.evt_valid_out = ~fifo_empty;
    assign evt_if.evt_type_out  = head_reg[9:8];
    assign evt_if.evt_value_out = head_reg[7:0];
    assign ovf_cnt_out          = ovf_cnt_reg;
    assign drop_cnt_out         = drop_cnt_reg;
    assign fifo_full_out        = fifo_full;

endmodule

// File: tb/tb_counter_event_mon.sv
// Bench for counter_event_mon: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based event model.
module tb_counter_event_mon;
    localparam int DEPTH = 4;
`ifdef COUNTER_EVT_MON_CMP_EVT_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  cnt;
    logic        ovf;
    logic [7:0]  cmp_v;
    logic [15:0] ovf_cnt;
    logic [7:0]  drop_cnt;
    logic        full;

    counter_event_mon_if evt_if ();

    counter_event_mon #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .en_ctrl_in    (en),
        .counter_in    (cnt),
        .ovf_in        (ovf),
`ifdef COUNTER_EVT_MON_CMP_EVT_EN
        .cmp_in        (cmp_v),
`endif
        .evt_if        (evt_if),
        .ovf_cnt_out   (ovf_cnt),
        .drop_cnt_out  (drop_cnt),
        .fifo_full_out (full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Behavioural model: a record queue plus the two statistics.
    bit [9:0] q[$];
    int       m_ovfcnt;
    int       m_drop;
    bit [7:0] m_prev_cnt;
    bit       m_prev_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_step();
        int  e_ovf, e_wu, e_wd, e_cmp, n_evt, drops;
        bit  [1:0] t;
        if (rst) begin
            q.delete();
            m_ovfcnt   = 0;
            m_drop     = 0;
            m_prev_cnt = 8'h00;
            m_prev_ovf = 1'b0;
            return;
        end
        e_ovf = (en && ovf && !m_prev_ovf) ? 1 : 0;
        e_wu  = (en && m_prev_cnt == 8'hFF && cnt == 8'h00) ? 1 : 0;
        e_wd  = (en && m_prev_cnt == 8'h00 && cnt == 8'hFF) ? 1 : 0;
        e_cmp = (CMP_ON && en && cnt == cmp_v && cnt != m_prev_cnt) ? 1 : 0;
        n_evt = e_ovf + e_wu + e_wd + e_cmp;
        drops = 0;
        if (q.size() > 0 && evt_if.evt_ready_in) void'(q.pop_front());
        if (n_evt > 0) begin
            drops = n_evt - 1;
            if (e_wu != 0)       t = 2'b10;
            else if (e_wd != 0)  t = 2'b11;
            else if (e_ovf != 0) t = 2'b00;
            else                 t = 2'b01;
            if (q.size() < DEPTH) q.push_back({t, cnt});
            else drops++;
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        if (e_ovf != 0 && m_ovfcnt < 65535) m_ovfcnt++;
        m_prev_cnt = cnt;
        m_prev_ovf = ovf;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("valid", evt_if.evt_valid_out, (q.size() != 0) ? 1 : 0);
            chk("full", full, (q.size() == DEPTH) ? 1 : 0);
            if (q.size() != 0) begin
                chk("head_type", evt_if.evt_type_out, int'(q[0][9:8]));
                chk("head_value", evt_if.evt_value_out, int'(q[0][7:0]));
            end
            chk("ovf_cnt", ovf_cnt, m_ovfcnt);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic step(input bit r, input bit e, input bit [7:0] c, input bit o, input bit rd);
        rst = r;
        en  = e;
        cnt = c;
        ovf = o;
        evt_if.evt_ready_in = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_head(input string name, input int t, input int v);
        chk({name, "_valid"}, evt_if.evt_valid_out, 1);
        chk({name, "_type"}, evt_if.evt_type_out, t);
        chk({name, "_value"}, evt_if.evt_value_out, v);
        $display("rec %s type=%0d value=%02h", name, evt_if.evt_type_out, evt_if.evt_value_out);
    endtask

    initial begin
        bit [7:0] c;
        bit       r, e, o, rd;
        rst = 1'b1; en = 1'b0; cnt = 8'h00; ovf = 1'b0; cmp_v = 8'h80;
        evt_if.evt_ready_in = 1'b0;
        do_reset();
        check_en = 1'b1;

        // Reset values
        chk("rst_valid", evt_if.evt_valid_out, 0);
        chk("rst_full", full, 0);
        chk("rst_type", evt_if.evt_type_out, 0);
        chk("rst_value", evt_if.evt_value_out, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);

        // Ramp through overflow: OVF/FF then WRAP_UP/00
        step(0, 1, 8'hFD, 0, 0);
        step(0, 1, 8'hFE, 0, 0);
        step(0, 1, 8'hFF, 1, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h01, 0, 0);
        chk("ramp_ovf_cnt", ovf_cnt, 1);
        chk("ramp_drop_cnt", drop_cnt, 0);
        expect_head("ramp0", 0, 8'hFF);
        step(0, 1, 8'h01, 0, 1);
        expect_head("ramp1", 2, 8'h00);
        step(0, 1, 8'h01, 0, 1);
        chk("ramp_empty", evt_if.evt_valid_out, 0);

        // Down-wrap with simultaneous overflow: WRAP_DN wins, OVF counted and dropped
        do_reset();
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'hFF, 1, 0);
        chk("wrapdn_drop", drop_cnt, 1);
        chk("wrapdn_ovf_cnt", ovf_cnt, 1);
        expect_head("wrapdn", 3, 8'hFF);

        // Six OVF events into a 4-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 12; i++) step(0, 1, 8'h20 + 8'(i), (i % 2) == 0, 0);
        chk("fill_full", full, 1);
        chk("fill_drop", drop_cnt, 2);
        chk("fill_ovf_cnt", ovf_cnt, 6);
        for (int k = 0; k < 4; k++) begin
            expect_head("drain", 0, 8'h20 + 2 * k);
            step(0, 1, 8'h40, 0, 1);
        end
        chk("drain_empty", evt_if.evt_valid_out, 0);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) step(0, 1, 8'h50 + 8'(i), (i % 2) == 0, 0);
        chk("full2_full", full, 1);
        step(0, 1, 8'h60, 1, 1);
        chk("pp_drop", drop_cnt, 2);
        chk("pp_full", full, 1);
        chk("pp_ovf_cnt", ovf_cnt, 11);
        expect_head("pp0", 0, 8'h52);
        step(0, 1, 8'h61, 0, 1);
        expect_head("pp1", 0, 8'h54);
        step(0, 1, 8'h61, 0, 1);
        expect_head("pp2", 0, 8'h56);
        step(0, 1, 8'h61, 0, 1);
        expect_head("pp3", 0, 8'h60);
        step(0, 1, 8'h61, 0, 1);

        // Mid-operation reset flushes; disabled detection produces nothing
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 8'h70 + 8'(i), (i % 2) == 0, 0);
        chk("pre_flush_valid", evt_if.evt_valid_out, 1);
        step(1, 1, 8'h76, 1, 0);
        chk("flush_valid", evt_if.evt_valid_out, 0);
        chk("flush_ovf_cnt", ovf_cnt, 0);
        step(0, 0, 8'hFD, 0, 0);
        step(0, 0, 8'hFE, 0, 0);
        step(0, 0, 8'hFF, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h01, 0, 0);
        chk("dis_valid", evt_if.evt_valid_out, 0);
        chk("dis_ovf_cnt", ovf_cnt, 0);

        if (CMP_ON) begin
            // Compare match: one record even while the value is held
            do_reset();
            cmp_v = 8'h10;
            step(0, 1, 8'h0E, 0, 0);
            step(0, 1, 8'h0F, 0, 0);
            for (int i = 0; i < 4; i++) step(0, 1, 8'h10, 0, 0);
            step(0, 1, 8'h11, 0, 0);
            step(0, 1, 8'h12, 0, 0);
            expect_head("cmp", 1, 8'h10);
            step(0, 1, 8'h12, 0, 1);
            chk("cmp_single", evt_if.evt_valid_out, 0);
            cmp_v = 8'h80;
        end

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 700; i++) step(0, 1, 8'h30, (i % 2) == 0, 0);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_ovf_cnt", ovf_cnt, 350);

        // Randomized traffic
        do_reset();
        c = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = c + 8'd1;
                4, 5:       c = c - 8'd1;
                6:          c = 8'($urandom);
                7:          c = 8'h00;
                8:          c = 8'hFF;
                default:    c = c;
            endcase
            case ($urandom_range(0, 3))
                0:       cmp_v = 8'h00;
                1:       cmp_v = 8'hFF;
                2:       cmp_v = c;
                default: cmp_v = 8'($urandom);
            endcase
            o  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : (c == 8'hFF);
            e  = ($urandom_range(0, 7) != 0);
            r  = ($urandom_range(0, 199) == 0);
            rd = (((i / 100) % 4) == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            step(r, e, c, o, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/counter_event_mon.md
COUNTER_EVENT_MON -- requirements
Module: counter_event_mon

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of event records buffered; SHALL be a power of two, 2..16.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 en_ctrl_in  input  1  event detection enable; when 0, no events SHALL be generated.
REQ-005 counter_in  input  8  sampled counter value, driven by the upstream counter's counter_out.
REQ-006 ovf_in  input  1  upstream overflow flag, high when the counter equals 8'hFF.
REQ-007 cmp_in  input  8  compare value; present only when CMP_EVT_EN is defined.
REQ-008 evt_valid_out  output  1  high when an event record is available at the FIFO head.
REQ-009 evt_ready_in  input  1  consumer accepts the head record when evt_valid_out and evt_ready_in are both high.
REQ-010 evt_type_out  output  2  head record type: 00 OVF, 01 CMP, 10 WRAP_UP, 11 WRAP_DN.
REQ-011 evt_value_out  output  8  counter_in value captured with the head record.
REQ-012 ovf_cnt_out  output  16  saturating count of detected OVF events.
REQ-013 drop_cnt_out  output  8  saturating count of discarded events.
REQ-014 fifo_full_out  output  1  high when the FIFO holds FIFO_DEPTH records.

Function
REQ-015 Registers cnt_prev (8 bit) and ovf_prev (1 bit) SHALL capture counter_in and ovf_in every cycle, regardless of en_ctrl_in.
REQ-016 OVF SHALL be detected when en_ctrl_in=1, ovf_in=1 and ovf_prev=0.
REQ-017 WRAP_UP SHALL be detected when en_ctrl_in=1, cnt_prev=8'hFF and counter_in=8'h00.
REQ-018 WRAP_DN SHALL be detected when en_ctrl_in=1, cnt_prev=8'h00 and counter_in=8'hFF.
REQ-019 CMP SHALL be detected when en_ctrl_in=1, counter_in=cmp_in and counter_in!=cnt_prev (CMP_EVT_EN only).
REQ-020 At most one record SHALL be pushed per cycle, chosen by priority WRAP_UP/WRAP_DN > OVF > CMP.
REQ-021 Each lower-priority event detected in the same cycle SHALL increment drop_cnt_out by one; for example, WRAP_DN with OVF adds 1.
REQ-022 A pushed record SHALL be {type, counter_in} as sampled in the detection cycle.
REQ-023 Latency: evt_valid_out SHALL rise on the first edge after detection when the FIFO was empty.
REQ-024 evt_type_out and evt_value_out SHALL remain stable while evt_valid_out=1 and evt_ready_in=0.
REQ-025 The FIFO SHALL be first-in first-out; evt_valid_out SHALL equal (occupancy != 0).
REQ-026 When the FIFO is full and no pop occurs, a push SHALL be discarded and drop_cnt_out incremented.
REQ-027 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted.
REQ-028 Push and pop on an empty FIFO SHALL NOT bypass; valid rises next cycle.
REQ-029 ovf_cnt_out SHALL count every detected OVF event, even when the record is dropped or outranked, and SHALL saturate at 16'hFFFF.
REQ-030 drop_cnt_out SHALL saturate at 8'hFF; both counters SHALL be cleared only by reset.
REQ-031 While en_ctrl_in=0, the FIFO SHALL continue to drain normally.

Reset
REQ-032 When rst_in=1 at a rising edge, the block SHALL clear cnt_prev to 8'h00, ovf_prev to 0, FIFO occupancy and pointers to 0, and ovf_cnt_out and drop_cnt_out to 0.
REQ-033 Output values after reset: evt_valid_out=0, fifo_full_out=0, evt_type_out=00, evt_value_out=8'h00.
REQ-034 Reset asserted mid-operation SHALL flush pending records; no event SHALL be detected in the reset cycle.

Configuration
REQ-035 Macro COUNTER_EVT_MON_CMP_EVT_EN, when defined, SHALL include port cmp_in and CMP detection.
REQ-036 When the macro is undefined, cmp_in SHALL be absent, type 01 SHALL never be produced, and all other behaviour SHALL be unchanged.

Verification
REQ-037 counter_in ramps 8'hFD to 8'h01 with ovf_in tracking, en_ctrl_in=1 -> records OVF/8'hFF then WRAP_UP/8'h00; ovf_cnt_out=1.
REQ-038 counter_in steps 8'h00 to 8'hFF with ovf_in rising -> one WRAP_DN/8'hFF record; drop_cnt_out=1; ovf_cnt_out=1.
REQ-039 Macro defined, cmp_in=8'h10, ramp 8'h0E to 8'h12, then hold 8'h10 for 3 cycles -> exactly one CMP/8'h10 record.
REQ-040 FIFO_DEPTH=4, evt_ready_in=0, 6 OVF events -> fifo_full_out=1, drop_cnt_out=2; drain returns 4 records in order.
REQ-041 FIFO full, an event arrives with evt_ready_in=1 in the same cycle -> push accepted, drop_cnt_out unchanged, occupancy stays 4.
REQ-042 rst_in pulsed with 3 records queued -> next cycle evt_valid_out=0 and ovf_cnt_out=0; en_ctrl_in=0 with ramp through 8'hFF -> no records.
